// File: rtl/dbus_arbiter_pkg.sv
// dbus_arbiter_pkg: state and owner encodings shared by the data-bus arbiter files
package dbus_arbiter_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;
endpackage

// File: rtl/dbus_arbiter_rr_pick.sv
// dbus_arbiter_rr_pick: cpu-priority winner select with dma anti-starvation counter update
module dbus_arbiter_rr_pick
  import dbus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int SW = 3
) (
  input  logic          cpu_req,
  input  logic          dma_req,
  input  logic [SW-1:0] starve_cnt,
  output logic          win,
  output logic          owner,
  output logic [SW-1:0] starve_nxt
);
  logic starved;
  always_comb begin
    starved = starve_cnt == SW'(STARVE_MAX);
    win = cpu_req | dma_req;
    owner = (dma_req & (~cpu_req | starved)) ? OWN_DMA : OWN_CPU;
    starve_nxt = (owner == OWN_CPU && dma_req) ? (starved ? starve_cnt : starve_cnt + 1'b1) : '0;
  end
endmodule

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares the data bus between MEM-stage cpu port and uart loader dma port
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int ACC_LAT = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [1:0] state;
  logic [2:0] lat_cnt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic owner, win, pick, sel_wr;
  logic [31:0] sel_addr, sel_wdata;
  dbus_arbiter_rr_pick #(.STARVE_MAX(STARVE_MAX), .SW(SW)) u_pick (
    .cpu_req(cpu_req),
    .dma_req(dma_req),
    .starve_cnt(starve_cnt),
    .win(win),
    .owner(pick),
    .starve_nxt(starve_nxt)
  );
  always_comb begin
    sel_wr = pick ? dma_wr : cpu_wr;
    sel_addr = pick ? dma_addr : cpu_addr;
    sel_wdata = pick ? dma_wdata : cpu_wdata;
  end
  assign cpu_stall = cpu_req & ~cpu_ack;
  // strobes and acks are single-cycle pulses, so they default low every cycle
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      lat_cnt <= '0;
      starve_cnt <= '0;
      owner <= OWN_CPU;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        ST_IDLE: if (win) begin
          owner <= pick;
          starve_cnt <= starve_nxt;
          mem_rd <= ~sel_wr;
          mem_wr <= sel_wr;
          mem_addr <= sel_addr & ~32'd3;
          mem_wdata <= sel_wdata;
          state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          lat_cnt <= 3'(ACC_LAT - 1);
          cpu_ack <= mem_wr & (owner == OWN_CPU);
          dma_ack <= mem_wr & (owner == OWN_DMA);
          state <= mem_wr ? ST_ACK : ST_WAIT;
        end
        ST_WAIT: if (lat_cnt != 3'd0) lat_cnt <= lat_cnt - 3'd1;
        else begin
          if (owner == OWN_DMA) dma_rdata <= mem_rdata;
          else cpu_rdata <= mem_rdata;
          cpu_ack <= owner == OWN_CPU;
          dma_ack <= owner == OWN_DMA;
          state <= ST_ACK;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed scenarios plus random traffic against a transaction-timing reference model
module tb_dbus_arbiter;
  localparam int LAT = 2;
  localparam int SMAX = 4;
  logic sysclk = 1'b0, reset = 1'b0;
  logic cpu_req = 1'b0, cpu_wr = 1'b0, dma_req = 1'b0, dma_wr = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0, mem_rdata = '0;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic cpu_ack, dma_ack, cpu_stall, mem_rd, mem_wr;
  int n_chk = 0, n_err = 0, cyc = 0;
  bit auto_en = 0, fix_en = 0;
  logic [31:0] fix_val = '0;
  int p_cpu = 0, p_dma = 0, w_cpu = 50, w_dma = 50, p_drop = 0;
  bit busy = 0;
  logic m_own, m_wr;
  logic [31:0] m_addr, m_wdata, cap;
  logic [31:0] rd_exp [2] = '{32'd0, 32'd0};
  int t_iss, t_ack, starve = 0;

  dbus_arbiter #(.ACC_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .sysclk(sysclk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_acks"}, {30'd0, cpu_ack, dma_ack}, 0);
    check({tag, "_strobes"}, {30'd0, mem_rd, mem_wr}, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 0);
    check({tag, "_dma_rdata"}, dma_rdata, 0);
  endtask

  // Reference: a granted access strobes the cycle after the grant and acks 2 (write)
  // or 2+LAT (read) cycles after it; the bus is free again the cycle after the ack.
  task automatic model_step();
    logic e_iss, e_ack;
    e_iss = busy && cyc == t_iss;
    e_ack = busy && cyc == t_ack;
    if (busy && !m_wr && cyc == t_ack - 1) cap = mem_rdata;
    if (e_ack && !m_wr) rd_exp[m_own] = cap;
    check("mem_rd", mem_rd, e_iss && !m_wr);
    check("mem_wr", mem_wr, e_iss && m_wr);
    if (e_iss) check("mem_addr", mem_addr, {m_addr[31:2], 2'b00});
    if (e_iss && m_wr) check("mem_wdata", mem_wdata, m_wdata);
    check("cpu_ack", cpu_ack, e_ack && !m_own);
    check("dma_ack", dma_ack, e_ack && m_own);
    check("cpu_rdata", cpu_rdata, rd_exp[0]);
    check("dma_rdata", dma_rdata, rd_exp[1]);
    check("cpu_stall", cpu_stall, cpu_req && !(e_ack && !m_own));
    if (e_ack) busy = 0;
    else if (!busy && (cpu_req || dma_req)) begin
      m_own = dma_req && (!cpu_req || starve == SMAX);
      starve = (!m_own && dma_req) ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
      m_wr = m_own ? dma_wr : cpu_wr;
      m_addr = m_own ? dma_addr : cpu_addr;
      m_wdata = m_own ? dma_wdata : cpu_wdata;
      t_iss = cyc + 1;
      t_ack = cyc + 2 + (m_wr ? 0 : LAT);
      busy = 1;
    end
  endtask

  always @(negedge sysclk) begin
    #1;
    if (!reset) begin
      busy = 0;
      starve = 0;
      rd_exp[0] = '0;
      rd_exp[1] = '0;
    end else model_step();
  end

  task automatic tick();
    @(negedge sysclk);
    mem_rdata = fix_en ? fix_val : $urandom;
    if (auto_en) begin
      if (cpu_ack || !cpu_req) begin
        cpu_req = $urandom_range(99) < p_cpu;
        cpu_wr = $urandom_range(99) < w_cpu;
        cpu_addr = $urandom;
        cpu_wdata = $urandom;
      end else if ($urandom_range(99) < p_drop) cpu_req = 1'b0;
      if (dma_ack || !dma_req) begin
        dma_req = $urandom_range(99) < p_dma;
        dma_wr = $urandom_range(99) < w_dma;
        dma_addr = $urandom;
        dma_wdata = $urandom;
      end else if ($urandom_range(99) < p_drop) dma_req = 1'b0;
    end
  endtask

  initial begin
    int tc, td, n, got;
    bit done;
    repeat (3) tick();
    check_zero("reset");
    check("reset_stall", cpu_stall, 0);
    tick();
    reset = 1'b1;
    repeat (2) tick();

    fix_en = 1;
    fix_val = 32'hDEAD_BEEF;
    tick();
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h0000_0104;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("rd_stall", cpu_stall, k < 4);
      if (k == 1) begin
        check("rd_strobe", mem_rd, 1);
        check("rd_addr", mem_addr, 32'h0000_0104);
      end
      check("rd_ack", cpu_ack, k == 4);
      if (k == 4) check("rd_data", cpu_rdata, 32'hDEAD_BEEF);
    end
    cpu_req = 0;

    tick();
    dma_req = 1; dma_wr = 1; dma_addr = 32'h0000_0203; dma_wdata = 32'h1234_5678;
    for (int k = 1; k <= 2; k++) begin
      tick();
      check("dw_stall", cpu_stall, 0);
      if (k == 1) begin
        check("dw_strobe", mem_wr, 1);
        check("dw_addr", mem_addr, 32'h0000_0200);
        check("dw_wdata", mem_wdata, 32'h1234_5678);
      end
      check("dw_ack", dma_ack, k == 2);
    end
    dma_req = 0;

    tick();
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h0000_0040;
    dma_req = 1; dma_wr = 1; dma_addr = 32'h0000_0080; dma_wdata = 32'hA5A5_0001;
    tc = -1;
    for (int k = 0; k < 20 && tc < 0; k++) begin
      tick();
      check("sim_no_dma_first", mem_wr | dma_ack, 0);
      if (cpu_ack) begin tc = cyc; cpu_req = 0; end
    end
    check("sim_cpu_acked", tc >= 0, 1);
    td = -1;
    for (int k = 0; k < 20 && td < 0; k++) begin
      tick();
      if (mem_wr) td = cyc;
    end
    check("sim_dma_strobe_cycle", td, tc + 2);
    done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      tick();
      if (dma_ack) begin done = 1; dma_req = 0; end
    end
    check("sim_dma_acked", done, 1);

    tick();
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h0000_0010;
    tick();
    check("lw_issue", mem_rd, 1);
    cpu_req = 0;
    n = 0;
    repeat (8) begin tick(); n += int'(cpu_ack); end
    check("lw_ack_count", n, 1);

    tick();
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h0000_0020;
    repeat (2) tick();
    check("rst_in_wait", mem_rd | cpu_ack, 0);
    #2 reset = 1'b0;
    cpu_req = 0;
    #1 check_zero("rst_mid");
    repeat (2) tick();
    reset = 1'b1;
    repeat (6) begin
      tick();
      check("rst_quiet", {30'd0, cpu_ack | dma_ack, mem_rd | mem_wr}, 0);
    end

    fix_en = 0;
    p_cpu = 100; w_cpu = 100; p_dma = 100; w_dma = 100; p_drop = 0;
    auto_en = 1;
    got = 0;
    for (int k = 0; k < 200 && got < 6; k++) begin
      tick();
      if (cpu_ack || dma_ack) begin
        check("starve_seq", dma_ack, got == 4);
        got++;
      end
    end
    check("starve_grants", got, 6);
    auto_en = 0;
    cpu_req = 0; dma_req = 0;
    repeat (10) tick();

    p_cpu = 50; p_dma = 40; w_cpu = 50; w_dma = 50; p_drop = 5;
    auto_en = 1;
    repeat (4000) tick();
    auto_en = 0;
    cpu_req = 0; dma_req = 0;
    repeat (20) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
